pattern_gen: RTL



---
 rtl/pattern_gen_pkg.sv | 34 +++
 rtl/pattern_gen_tclk_div.sv | 47 ++++
 rtl/pattern_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_gen_pkg
// Shared types and defaults for the table-driven pattern generator.
//   state_t  : playback FSM states (IDLE, RUN, DONE)
//   entry_t  : table entry layout {value, hold} at the default widths
//   DEF_*    : default parameter values used by pattern_gen and tclk_div
//   cnt_bits : width of a counter that must hold the values 0..n-1
// -----------------------------------------------------------------------------
package pattern_gen_pkg;

   localparam int DEF_WIDTH    = 1;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_CNT_W    = 8;
   localparam int DEF_HALF_PER = 50;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default-width entry layout; pattern_gen declares the same layout at its
   // own parameter widths.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] value;
      logic [DEF_CNT_W-1:0] hold;
   } entry_t;

   // Never returns 0 so a divide-by-one counter still has a legal width.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_gen_tclk_div.sv
// -----------------------------------------------------------------------------
// tclk_div
// Half-period divider producing the gated test clock.
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_en    : count enable (synchronous)
//   i_clr   : synchronous clear, wins over i_en; forces o_tclk low, phase 0
//   o_tclk  : registered test clock, toggles every HALF_PER enabled cycles
// -----------------------------------------------------------------------------
module tclk_div
   import pattern_gen_pkg::*;
#(
   parameter int HALF_PER = DEF_HALF_PER
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tclk
);

   localparam int            CW   = cnt_bits(HALF_PER);
   localparam logic [CW-1:0] TERM = CW'(HALF_PER - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tclk;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_tclk <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_tclk <= 1'b0;
      end else if (i_en) begin
         if (r_cnt == TERM) begin
            r_cnt  <= '0;
            r_tclk <= ~r_tclk;
         end else begin
            r_cnt  <= r_cnt + CW'(1);
         end
      end
   end

   assign o_tclk = r_tclk;

endmodule

// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
// Replays a programmable table of (value, hold) entries on o_dout and emits a
// gated test clock while playing. Single-shot and loop playback.
//   i_clk, i_rst    : system clock, asynchronous active-high reset
//   i_wr_en         : table write strobe (accepted in every state)
//   i_wr_addr/value/hold : entry written; entry plays for hold+1 cycles
//   i_last, i_loop  : final entry index and wrap enable, captured at start
//   i_start, i_stop : begin / abort playback (stop wins when both are high)
//   o_dout          : value of the entry currently driven
//   o_tclk          : test clock, low outside RUN, period 2*HALF_PER
//   o_busy          : high while in RUN
//   o_done          : one-cycle pulse when a single-shot run completes
//   o_idx           : index of the entry currently driven
//   o_dbg_state     : current FSM state (state_t encoding)
// All control inputs are level strobes sampled on the rising clock edge;
// there is no back-pressure.
// -----------------------------------------------------------------------------
module pattern_gen
   import pattern_gen_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int HALF_PER = DEF_HALF_PER,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_value,
   input  logic [CNT_W-1:0] i_wr_hold,
   input  logic [AW-1:0]    i_last,
   input  logic             i_loop,
   input  logic             i_start,
   input  logic             i_stop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_tclk,
   output logic             o_busy,
   output logic             o_done,
   output logic [AW-1:0]    o_idx,
   output logic [1:0]       o_dbg_state
);

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic [CNT_W-1:0] hold;
   } tab_entry_t;

   // Table: not reset, so a mid-run reset keeps the programmed pattern.
   tab_entry_t r_tab [DEPTH];

   state_t           r_state;
   logic [AW-1:0]    r_idx;
   logic [WIDTH-1:0] r_dout;
   logic [CNT_W-1:0] r_cnt;
   logic [AW-1:0]    r_last;
   logic             r_loop;
   logic             r_done;

   state_t           w_state_nxt;
   logic [AW-1:0]    w_idx_nxt;
   logic [WIDTH-1:0] w_dout_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [AW-1:0]    w_last_nxt;
   logic             w_loop_nxt;
   logic             w_done_nxt;
   logic [AW-1:0]    w_rd_addr;
   tab_entry_t       w_rd;
   logic             w_load;      // load entry w_rd_addr into idx/dout/cnt
   logic             w_start_acc; // start accepted: restart test-clock phase
   logic             w_tclk_en;
   logic             w_tclk_clr;

   // Single write port. The read below uses the pre-edge array contents, so
   // an entry written and loaded on the same edge plays its old value.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_tab[i_wr_addr] <= '{value: i_wr_value, hold: i_wr_hold};
      end
   end

   assign w_rd = r_tab[w_rd_addr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_dout  <= '0;
         r_cnt   <= '0;
         r_last  <= '0;
         r_loop  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_dout  <= w_dout_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_loop  <= w_loop_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_dout_nxt  = r_dout;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      w_loop_nxt  = r_loop;
      w_done_nxt  = 1'b0;
      w_rd_addr   = '0;
      w_load      = 1'b0;
      w_start_acc = 1'b0;

      case (r_state)
         IDLE, DONE: begin
            if (i_stop) begin
               w_state_nxt = IDLE;
               w_dout_nxt  = '0;
               w_idx_nxt   = '0;
            end else if (i_start) begin
               w_state_nxt = RUN;
               w_last_nxt  = i_last;
               w_loop_nxt  = i_loop;
               w_rd_addr   = '0;
               w_load      = 1'b1;
               w_start_acc = 1'b1;
            end
         end
         RUN: begin
            // start is deliberately ignored here.
            if (i_stop) begin
               w_state_nxt = IDLE;
               w_dout_nxt  = '0;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (r_idx != r_last) begin
               w_rd_addr = r_idx + AW'(1);
               w_load    = 1'b1;
            end else if (r_loop) begin
               // Wrap straight to entry 0: no idle cycle between passes.
               w_rd_addr = '0;
               w_load    = 1'b1;
            end else begin
               // dout and idx hold the last entry while DONE.
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_dout_nxt  = '0;
            w_idx_nxt   = '0;
         end
      endcase

      if (w_load) begin
         w_idx_nxt  = w_rd_addr;
         w_dout_nxt = w_rd.value;
         w_cnt_nxt  = w_rd.hold;
      end
   end

   // The divider counts only on cycles that stay in RUN and is held clear
   // otherwise, so tclk is low outside RUN and its phase restarts on every
   // accepted start but is untouched by a loop wrap.
   assign w_tclk_en  = (r_state == RUN) && (w_state_nxt == RUN);
   assign w_tclk_clr = w_start_acc || (w_state_nxt != RUN);

   tclk_div #(
      .HALF_PER (HALF_PER)
   ) u_tclk_div (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (w_tclk_en),
      .i_clr  (w_tclk_clr),
      .o_tclk (o_tclk)
   );

   assign o_dout      = r_dout;
   assign o_busy      = (r_state == RUN);
   assign o_done      = r_done;
   assign o_idx       = r_idx;
   assign o_dbg_state = r_state;

endmodule
